// File: rtl/hdmi_period_scheduler.sv
// -----------------------------------------------------------------------------
// hdmi_period_scheduler
//   Raster timing generator and HDMI period scheduler. Produces the pixel
//   coordinates, sync levels and per-pixel period mode (control, video
//   preamble/guard, video, data-island preamble/guard/packets) that drive the
//   three TMDS channel encoders. Data islands of 1..MAX_PACKETS packets are
//   scheduled on demand from the packet assembler via packet_valid/ready.
//
//   Optional feature macro: HDMI_DATA_ISLAND_EN
//     defined     : data-island FSM present.
//     not defined : plain DVI timing (mode never 3/4, ctrl never 0101,
//                   packet_ready and packet_pos held at 0).
//
// Ports
//   clk_pixel     in   pixel clock
//   reset         in   synchronous, active-high reset
//   cx            out  column 0..FW-1
//   cy            out  line 0..FH-1
//   hsync, vsync  out  sync levels, active level set by HSYNC_POL/VSYNC_POL
//   mode          out  0 control, 1 video, 2 video guard, 3 island packet,
//                      4 island guard
//   ctrl          out  {ctrl3..ctrl0}: 0101 island preamble, 0001 video
//                      preamble, else 0000
//   packet_valid  in   assembler has a packet to send
//   packet_ready  out  one-cycle pulse on the first cycle of a packet slot
//   packet_pos    out  sub-packet index 0..31 inside a slot, else 0
//
// Every output is registered and describes the pixel at cx/cy of the same
// cycle, so all next-pixel values are formed combinationally from *_d terms.
// -----------------------------------------------------------------------------
module hdmi_period_scheduler #(
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int H_ACTIVE     = 640,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int V_ACTIVE     = 480,
   parameter bit HSYNC_POL    = 1'b0,
   parameter bit VSYNC_POL    = 1'b0,
   parameter int ISLAND_START = 150,
   parameter int MAX_PACKETS  = 2,
   parameter int BIT_WIDTH    = 9,
   parameter int BIT_HEIGHT   = 9
) (
   input  logic                clk_pixel,
   input  logic                reset,
   output logic [BIT_WIDTH:0]  cx,
   output logic [BIT_HEIGHT:0] cy,
   output logic                hsync,
   output logic                vsync,
   output logic [2:0]          mode,
   output logic [3:0]          ctrl,
   input  logic                packet_valid,
   output logic                packet_ready,
   output logic [4:0]          packet_pos
);

   localparam int CXW = BIT_WIDTH + 1;
   localparam int CYW = BIT_HEIGHT + 1;
   localparam int FW  = H_FRONT + H_SYNC + H_BACK + H_ACTIVE;
   localparam int FH  = V_FRONT + V_SYNC + V_BACK + V_ACTIVE;
   localparam int AS  = FW - H_ACTIVE;
   localparam int VS  = FH - V_ACTIVE;

   localparam logic [BIT_WIDTH:0]  CX_LAST   = CXW'(FW - 1);
   localparam logic [BIT_WIDTH:0]  HS_START  = CXW'(H_FRONT);
   localparam logic [BIT_WIDTH:0]  HS_END    = CXW'(H_FRONT + H_SYNC);
   localparam logic [BIT_WIDTH:0]  VID_PRE   = CXW'(AS - 10);
   localparam logic [BIT_WIDTH:0]  VID_GUARD = CXW'(AS - 2);
   localparam logic [BIT_WIDTH:0]  VID_START = CXW'(AS);
   localparam logic [BIT_HEIGHT:0] CY_LAST   = CYW'(FH - 1);
   localparam logic [BIT_HEIGHT:0] VS_START  = CYW'(V_FRONT);
   localparam logic [BIT_HEIGHT:0] VS_END    = CYW'(V_FRONT + V_SYNC);
   localparam logic [BIT_HEIGHT:0] CY_ACTIVE = CYW'(VS);

   localparam logic [2:0] MODE_CTRL      = 3'd0;
   localparam logic [2:0] MODE_VIDEO     = 3'd1;
   localparam logic [2:0] MODE_VID_GUARD = 3'd2;
   localparam logic [2:0] MODE_PACKET    = 3'd3;
   localparam logic [2:0] MODE_ISL_GUARD = 3'd4;
   localparam logic [3:0] CTRL_NONE      = 4'b0000;
   localparam logic [3:0] CTRL_VIDEO     = 4'b0001;
   localparam logic [3:0] CTRL_ISLAND    = 4'b0101;

   logic [BIT_WIDTH:0]  cx_q, cx_d;
   logic [BIT_HEIGHT:0] cy_q, cy_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic [2:0]          mode_q, mode_d;
   logic [3:0]          ctrl_q, ctrl_d;
   logic                ready_q, ready_d;
   logic [4:0]          pos_q, pos_d;
   logic [2:0]          vid_mode;
   logic [3:0]          vid_ctrl;

   // Raster counters, sync levels and the video period of the next pixel.
   always_comb begin : timing_next
      // NOTE: every variable of a combinational block gets a default before
      // any branch, so no path leaves it unassigned and no latch is inferred.
      cx_d     = (cx_q == CX_LAST) ? '0 : cx_q + CXW'(1);
      cy_d     = cy_q;
      vid_mode = MODE_CTRL;
      vid_ctrl = CTRL_NONE;
      if (cx_q == CX_LAST) begin
         cy_d = (cy_q == CY_LAST) ? '0 : cy_q + CYW'(1);
      end
      hsync_d = (cx_d >= HS_START && cx_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = (cy_d >= VS_START && cy_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      if (cy_d >= CY_ACTIVE) begin
         if (cx_d >= VID_START) begin
            vid_mode = MODE_VIDEO;
         end else if (cx_d >= VID_GUARD) begin
            vid_mode = MODE_VID_GUARD;
         end else if (cx_d >= VID_PRE) begin
            vid_ctrl = CTRL_VIDEO;
         end
      end
   end

   always_ff @(posedge clk_pixel) begin : out_regs
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         cx_q    <= '0;
         cy_q    <= '0;
         hsync_q <= ~HSYNC_POL;
         vsync_q <= ~VSYNC_POL;
         mode_q  <= MODE_CTRL;
         ctrl_q  <= CTRL_NONE;
         ready_q <= 1'b0;
         pos_q   <= '0;
      end else begin
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         mode_q  <= mode_d;
         ctrl_q  <= ctrl_d;
         ready_q <= ready_d;
         pos_q   <= pos_d;
      end
   end

`ifdef HDMI_DATA_ISLAND_EN
   typedef enum logic [2:0] {
      ST_CTRL,
      ST_DI_PRE,
      ST_DI_LGUARD,
      ST_DI_PACKET,
      ST_DI_TGUARD
   } state_e;

   localparam logic [BIT_WIDTH:0] ISL_TRIG = CXW'(ISLAND_START - 1);

   state_e     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;    // cycle count within the current phase/slot
   logic [4:0] sent_q, sent_d;  // packet slots started in this island

   always_ff @(posedge clk_pixel) begin : fsm_state
      if (reset) begin
         state_q <= ST_CTRL;
         cnt_q   <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sent_q  <= sent_d;
      end
   end

   // State/count describe the current pixel; outputs are derived from the
   // next state so they line up with the registered cx/cy.
   always_comb begin : fsm_next
      state_d = state_q;
      cnt_d   = cnt_q + 5'd1;
      sent_d  = sent_q;
      mode_d  = vid_mode;
      ctrl_d  = vid_ctrl;
      ready_d = 1'b0;
      pos_d   = '0;
      case (state_q)
         ST_CTRL: begin
            cnt_d = '0;
            if (cy_q < CY_ACTIVE && cx_q == ISL_TRIG && packet_valid) begin
               state_d = ST_DI_PRE;
               sent_d  = '0;
            end
         end
         ST_DI_PRE: begin
            if (cnt_q == 5'd7) begin
               state_d = ST_DI_LGUARD;
               cnt_d   = '0;
            end
         end
         ST_DI_LGUARD: begin
            if (cnt_q == 5'd1) begin
               state_d = ST_DI_PACKET;
               cnt_d   = '0;
               sent_d  = 5'd1;
            end
         end
         ST_DI_PACKET: begin
            // cnt wraps 31->0 naturally when another slot follows.
            if (cnt_q == 5'd31) begin
               if (packet_valid && sent_q < 5'(MAX_PACKETS)) begin
                  sent_d = sent_q + 5'd1;
               end else begin
                  state_d = ST_DI_TGUARD;
               end
            end
         end
         ST_DI_TGUARD: begin
            if (cnt_q == 5'd1) begin
               state_d = ST_CTRL;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CTRL;
            cnt_d   = '0;
         end
      endcase

      case (state_d)
         ST_DI_PRE: begin
            mode_d = MODE_CTRL;
            ctrl_d = CTRL_ISLAND;
         end
         ST_DI_LGUARD, ST_DI_TGUARD: begin
            mode_d = MODE_ISL_GUARD;
            ctrl_d = CTRL_NONE;
         end
         ST_DI_PACKET: begin
            mode_d  = MODE_PACKET;
            ctrl_d  = CTRL_NONE;
            pos_d   = cnt_d;
            ready_d = (cnt_d == 5'd0);
         end
         default: ;
      endcase
   end
`else
   logic unused_packet_valid;
   assign unused_packet_valid = packet_valid;
   assign mode_d  = vid_mode;
   assign ctrl_d  = vid_ctrl;
   assign ready_d = 1'b0;
   assign pos_d   = '0;
`endif

   assign cx           = cx_q;
   assign cy           = cy_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign mode         = mode_q;
   assign ctrl         = ctrl_q;
   assign packet_ready = ready_q;
   assign packet_pos   = pos_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hdmi_period_scheduler
//   Randomised bench for hdmi_period_scheduler. Horizontal timing is the
//   640x480 default; the active height is shortened so a full frame fits in a
//   short run. A pixel-coordinate model predicts every output each cycle, and
//   a table of hand-computed pixel values pins the model.
// -----------------------------------------------------------------------------
module tb_hdmi_period_scheduler;

   localparam int H_FRONT = 16, H_SYNC = 96, H_BACK = 48, H_ACTIVE = 640;
   localparam int V_FRONT = 10, V_SYNC = 2, V_BACK = 33, V_ACTIVE = 12;
   localparam int FW = H_FRONT + H_SYNC + H_BACK + H_ACTIVE;   // 800
   localparam int FH = V_FRONT + V_SYNC + V_BACK + V_ACTIVE;   // 57
   localparam int AS = FW - H_ACTIVE;                          // 160
   localparam int VS = FH - V_ACTIVE;                          // 45
   localparam int ISLAND_START = 150;
   localparam int MAX_PACKETS  = 2;
   localparam int RESET_Y = 22, RESET_X = 170;
   localparam int N_STEPS = RESET_Y * FW + RESET_X + 1 + FW * FH + 2 * FW;

   logic       clk_pixel = 1'b0;
   logic       reset = 1'b1;
   logic       packet_valid = 1'b0;
   logic [9:0] cx, cy;
   logic       hsync, vsync, packet_ready;
   logic [2:0] mode;
   logic [3:0] ctrl;
   logic [4:0] packet_pos;

   always #5 clk_pixel = ~clk_pixel;

   hdmi_period_scheduler #(
      .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
      .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .ISLAND_START(ISLAND_START),
      .MAX_PACKETS(MAX_PACKETS), .BIT_WIDTH(9), .BIT_HEIGHT(9)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy),
      .hsync(hsync), .vsync(vsync), .mode(mode), .ctrl(ctrl),
      .packet_valid(packet_valid), .packet_ready(packet_ready),
      .packet_pos(packet_pos)
   );

   int vectors = 0, miscompares = 0;

   // Model state: current pixel and the island (if any) running on this line.
   int m_cx = 0, m_cy = 0;
   bit isl_on = 1'b0;
   int npk = 0;           // packet slots granted to the current island
   int line_mode = 0;     // 0 random valid, 1 valid held, 2 valid only at commit
   bit first = 1'b1, after_reset = 1'b0, reset_done = 1'b0;

   typedef struct { int y; int x; int sig; int val; } pin_t;
   pin_t  pins[$];
   string sig_name[8] = '{"hsync", "vsync", "mode", "ctrl", "ready", "pos", "cx", "cy"};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (model cx=%0d cy=%0d)",
                  name, act, exp, m_cx, m_cy);
      end
   endtask

   task automatic add_pin(input int y, input int x, input int sig, input int val);
      pin_t p;
      p.y = y; p.x = x; p.sig = sig; p.val = val;
      pins.push_back(p);
   endtask

   function automatic logic [31:0] dut_sig(input int sig);
      case (sig)
         0: return 32'(hsync);
         1: return 32'(vsync);
         2: return 32'(mode);
         3: return 32'(ctrl);
         4: return 32'(packet_ready);
         5: return 32'(packet_pos);
         6: return 32'(cx);
         default: return 32'(cy);
      endcase
   endfunction

   // Expected {hsync, vsync, mode, ctrl, ready, pos} for pixel (x, y).
   function automatic logic [14:0] expect_period(input int x, input int y);
      logic hs, vs, rd;
      logic [2:0] md;
      logic [3:0] ct;
      logic [4:0] ps;
      int off, p;
      hs = (x >= H_FRONT && x < H_FRONT + H_SYNC) ? 1'b0 : 1'b1;
      vs = (y >= V_FRONT && y < V_FRONT + V_SYNC) ? 1'b0 : 1'b1;
      md = 3'd0; ct = 4'b0000; rd = 1'b0; ps = 5'd0;
      if (y >= VS) begin
         if (x >= AS)          md = 3'd1;
         else if (x >= AS - 2) md = 3'd2;
         else if (x >= AS - 10) ct = 4'b0001;
      end else if (isl_on) begin
         off = x - ISLAND_START;
         if (off >= 0 && off < 8) ct = 4'b0101;
         else if (off >= 8 && off < 10) md = 3'd4;
         else if (off >= 10) begin
            p = off - 10;
            if (p < 32 * npk) begin
               md = 3'd3;
               ps = 5'(p % 32);
               rd = (p % 32 == 0);
            end else if (p < 32 * npk + 2) begin
               md = 3'd4;
            end
         end
      end
      return {hs, vs, md, ct, rd, ps};
   endfunction

   task automatic step();
      bit v, r;
      int p;
      @(negedge clk_pixel);
      check("position", {12'd0, cx, cy}, {12'd0, 10'(m_cx), 10'(m_cy)});
      check("period", {17'd0, hsync, vsync, mode, ctrl, packet_ready, packet_pos},
            {17'd0, expect_period(m_cx, m_cy)});
      foreach (pins[i]) begin
         if (pins[i].y == m_cy && pins[i].x == m_cx)
            check($sformatf("pin_y%0d_x%0d_%s", m_cy, m_cx, sig_name[pins[i].sig]),
                  dut_sig(pins[i].sig), 32'(pins[i].val));
      end
      if (first) begin
         check("reset_cx", 32'(cx), 32'd0);
         check("reset_cy", 32'(cy), 32'd0);
         check("reset_hsync", 32'(hsync), 32'd1);
         check("reset_vsync", 32'(vsync), 32'd1);
         check("reset_mode", 32'(mode), 32'd0);
         first = 1'b0;
      end
      if (after_reset) begin
         check("abort_mode", 32'(mode), 32'd0);
         check("abort_ready", 32'(packet_ready), 32'd0);
         check("abort_cx", 32'(cx), 32'd0);
         check("abort_cy", 32'(cy), 32'd0);
         after_reset = 1'b0;
      end

      // Stimulus for the coming edge.
      if (m_cx == 0) begin
         if (m_cy == 20)                       line_mode = 2;
         else if (m_cy == 21 || m_cy == RESET_Y || m_cy == 45) line_mode = 1;
         else                                  line_mode = $urandom_range(0, 2);
      end
      case (line_mode)
         0:       v = 1'($urandom_range(0, 1));
         1:       v = 1'b1;
         default: v = (m_cx == ISLAND_START - 1);
      endcase
      r = (!reset_done && m_cy == RESET_Y && m_cx == RESET_X);
      if (r) begin
         reset_done  = 1'b1;
         after_reset = 1'b1;
      end
      packet_valid = v;
      reset        = r;

      // Model advance.
      if (r) begin
         m_cx = 0; m_cy = 0; isl_on = 1'b0; npk = 0;
      end else begin
         if (isl_on) begin
            p = m_cx - ISLAND_START - 10;
            if (p == 32 * npk - 1 && v && npk < MAX_PACKETS) npk++;
            else if (p == 32 * npk + 1) isl_on = 1'b0;
         end
`ifdef HDMI_DATA_ISLAND_EN
         else if (m_cy < VS && m_cx == ISLAND_START - 1 && v) begin
            isl_on = 1'b1;
            npk    = 1;
         end
`endif
         if (m_cx == FW - 1) begin
            m_cx = 0;
            m_cy = (m_cy == FH - 1) ? 0 : m_cy + 1;
         end else begin
            m_cx++;
         end
      end
   endtask

   initial begin
      // Hand-computed pixel values (y, x, signal, value).
      add_pin(0, 0, 6, 0);     add_pin(0, 0, 7, 0);
      add_pin(0, 15, 0, 1);    add_pin(0, 16, 0, 0);
      add_pin(0, 111, 0, 0);   add_pin(0, 112, 0, 1);
      add_pin(0, 799, 6, 799); add_pin(1, 0, 6, 0);   add_pin(1, 0, 7, 1);
      add_pin(9, 0, 1, 1);     add_pin(10, 0, 1, 0);
      add_pin(11, 799, 1, 0);  add_pin(12, 0, 1, 1);
      add_pin(FH - 1, 799, 7, FH - 1);
      add_pin(45, 149, 3, 0);  add_pin(45, 150, 3, 1); add_pin(45, 157, 3, 1);
      add_pin(45, 158, 2, 2);  add_pin(45, 159, 2, 2); add_pin(45, 160, 2, 1);
      add_pin(45, 160, 4, 0);  add_pin(45, 799, 2, 1);
`ifdef HDMI_DATA_ISLAND_EN
      add_pin(20, 149, 3, 0);  add_pin(20, 150, 3, 5); add_pin(20, 157, 3, 5);
      add_pin(20, 158, 2, 4);  add_pin(20, 160, 2, 3); add_pin(20, 160, 4, 1);
      add_pin(20, 161, 5, 1);  add_pin(20, 191, 5, 31); add_pin(20, 192, 2, 4);
      add_pin(20, 192, 4, 0);  add_pin(20, 193, 2, 4); add_pin(20, 194, 2, 0);
      add_pin(21, 160, 4, 1);  add_pin(21, 192, 4, 1); add_pin(21, 192, 5, 0);
      add_pin(21, 223, 5, 31); add_pin(21, 224, 2, 4); add_pin(21, 224, 4, 0);
      add_pin(21, 225, 2, 4);  add_pin(21, 226, 2, 0);
      add_pin(RESET_Y, RESET_X, 2, 3);
`else
      add_pin(20, 150, 3, 0);  add_pin(20, 160, 2, 0); add_pin(20, 160, 4, 0);
      add_pin(21, 192, 4, 0);  add_pin(21, 224, 2, 0); add_pin(21, 170, 5, 0);
`endif

      reset        = 1'b1;
      packet_valid = 1'b0;
      repeat (3) @(posedge clk_pixel);
      for (int n = 0; n < N_STEPS; n++) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
